// File: rtl/ipf_lcu_feeder.sv
// Walks a 128x128 8-bit image in LCU raster order and streams it into IPF.
// Each pixel carries its LCU's filter parameters and coordinates. IPF busy stalls the stream.
module ipf_lcu_feeder #(
    parameter int IMG_AW = 14,
    parameter int PRM_AW = 6,
    parameter int PRM_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lcu_size_cfg,
    output logic              img_rd,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_data,
    output logic [PRM_AW-1:0] prm_addr,
    input  logic [PRM_W-1:0]  prm_data,
    input  logic              busy,
    input  logic              finish,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, STREAM, FLUSH, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       size_q, size_d;
    logic [5:0]       col_q, col_d, row_q, row_d;
    logic [2:0]       lx_q, lx_d, ly_q, ly_d;

    // Read issued last cycle; its data is on img_data/prm_data now.
    logic             ret_v_q, ret_v_d;
    logic [2:0]       ret_x_q, ret_x_d, ret_y_q, ret_y_d;

    logic             skid_v_q, skid_v_d;
    logic [7:0]       skid_data_q, skid_data_d;
    logic [PRM_W-1:0] skid_prm_q, skid_prm_d;
    logic [2:0]       skid_x_q, skid_x_d, skid_y_q, skid_y_d;

    logic             out_en_q, out_en_d;
    logic [7:0]       out_din_q, out_din_d;
    logic [PRM_W-1:0] out_prm_q, out_prm_d;
    logic [2:0]       out_x_q, out_x_d, out_y_q, out_y_d;

    logic [5:0]       s_max;
    logic [2:0]       n_max;
    logic             issue;
    logic             last_rd;

    always_comb begin
        case (size_q)
            2'd0:    begin s_max = 6'd15; n_max = 3'd7; end
            2'd1:    begin s_max = 6'd31; n_max = 3'd3; end
            default: begin s_max = 6'd63; n_max = 3'd1; end
        endcase
    end

    assign issue   = (state_q == STREAM) && !busy;
    assign last_rd = (col_q == s_max) && (row_q == s_max) && (lx_q == n_max) && (ly_q == n_max);

    always_comb begin
        case (size_q)
            2'd0: begin
                img_addr = IMG_AW'({ly_q[2:0], row_q[3:0], lx_q[2:0], col_q[3:0]});
                prm_addr = PRM_AW'({ly_q[2:0], lx_q[2:0]});
            end
            2'd1: begin
                img_addr = IMG_AW'({ly_q[1:0], row_q[4:0], lx_q[1:0], col_q[4:0]});
                prm_addr = PRM_AW'({ly_q[1:0], lx_q[1:0]});
            end
            default: begin
                img_addr = IMG_AW'({ly_q[0], row_q[5:0], lx_q[0], col_q[5:0]});
                prm_addr = PRM_AW'({ly_q[0], lx_q[0]});
            end
        endcase
    end

    // Frame sequencing and raster counters (col inner, then row, lcu_x, lcu_y).
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        col_d   = col_q;
        row_d   = row_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    size_d  = (lcu_size_cfg == 2'd3) ? 2'd2 : lcu_size_cfg;
                    col_d   = '0;
                    row_d   = '0;
                    lx_d    = '0;
                    ly_d    = '0;
                end
            end
            STREAM: begin
                if (issue) begin
                    if (last_rd) begin
                        state_d = FLUSH;
                    end
                    if (col_q != s_max) begin
                        col_d = col_q + 6'd1;
                    end else begin
                        col_d = '0;
                        if (row_q != s_max) begin
                            row_d = row_q + 6'd1;
                        end else begin
                            row_d = '0;
                            if (lx_q != n_max) begin
                                lx_d = lx_q + 3'd1;
                            end else begin
                                lx_d = '0;
                                ly_d = (ly_q == n_max) ? 3'd0 : ly_q + 3'd1;
                            end
                        end
                    end
                end
            end
            FLUSH: begin
                if (!busy && !ret_v_q && !skid_v_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Data that returns during a stall parks in the skid so the held re-read is never needed.
    always_comb begin
        ret_v_d     = issue;
        ret_x_d     = lx_q;
        ret_y_d     = ly_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_prm_d  = skid_prm_q;
        skid_x_d    = skid_x_q;
        skid_y_d    = skid_y_q;
        out_en_d    = out_en_q;
        out_din_d   = out_din_q;
        out_prm_d   = out_prm_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        if (busy) begin
            if (ret_v_q) begin
                skid_v_d    = 1'b1;
                skid_data_d = img_data;
                skid_prm_d  = prm_data;
                skid_x_d    = ret_x_q;
                skid_y_d    = ret_y_q;
            end
        end else begin
            skid_v_d = 1'b0;
            if (skid_v_q) begin
                out_en_d  = 1'b1;
                out_din_d = skid_data_q;
                out_prm_d = skid_prm_q;
                out_x_d   = skid_x_q;
                out_y_d   = skid_y_q;
            end else if (ret_v_q) begin
                out_en_d  = 1'b1;
                out_din_d = img_data;
                out_prm_d = prm_data;
                out_x_d   = ret_x_q;
                out_y_d   = ret_y_q;
            end else begin
                out_en_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            size_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lx_q        <= '0;
            ly_q        <= '0;
            ret_v_q     <= 1'b0;
            ret_x_q     <= '0;
            ret_y_q     <= '0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_prm_q  <= '0;
            skid_x_q    <= '0;
            skid_y_q    <= '0;
            out_en_q    <= 1'b0;
            out_din_q   <= '0;
            out_prm_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lx_q        <= lx_d;
            ly_q        <= ly_d;
            ret_v_q     <= ret_v_d;
            ret_x_q     <= ret_x_d;
            ret_y_q     <= ret_y_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_prm_q  <= skid_prm_d;
            skid_x_q    <= skid_x_d;
            skid_y_q    <= skid_y_d;
            out_en_q    <= out_en_d;
            out_din_q   <= out_din_d;
            out_prm_q   <= out_prm_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    assign img_rd       = (state_q == STREAM);
    assign in_en        = out_en_q;
    assign din          = out_din_q;
    assign ipf_type     = out_prm_q[23:22];
    assign ipf_band_pos = out_prm_q[21:17];
    assign ipf_wo_class = out_prm_q[16];
    assign ipf_offset   = out_prm_q[15:0];
    assign lcu_x        = out_x_q;
    assign lcu_y        = out_y_q;
    assign lcu_size     = size_q;
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Randomised frame-level bench for ipf_lcu_feeder against a pixel-list model built
// from image coordinates, with ROM models, stall/abort scenarios and literal spot checks.
module tb_ipf_lcu_feeder;

    logic        clk = 1'b0;
    logic        reset, start, finish, busy;
    logic [1:0]  lcu_size_cfg;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_data = 8'd0;
    logic [5:0]  prm_addr;
    logic [23:0] prm_data = 24'd0;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    ipf_lcu_feeder dut (
        .clk(clk), .reset(reset), .start(start), .lcu_size_cfg(lcu_size_cfg),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .prm_addr(prm_addr), .prm_data(prm_data), .busy(busy), .finish(finish),
        .in_en(in_en), .din(din), .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
        .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    always #5 clk = ~clk;

    logic [7:0]  img_rom [16384];
    logic [23:0] prm_rom [64];

    always @(posedge clk) begin
        if (img_rd) img_data <= img_rom[img_addr];
        prm_data <= prm_rom[prm_addr];
    end

    typedef struct {
        logic [7:0]  din;
        logic [23:0] prm;
        logic [2:0]  lx;
        logic [2:0]  ly;
        int          addr;
    } pix_t;

    pix_t        exp_q[$];
    pix_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          t0 = -1000;
    int          pix_cnt, last_en_cyc, done_cnt, done_cyc, fin_cyc;
    logic [7:0]  last_din = 8'd0;
    logic [63:0] prm_seen = '0;
    logic [1:0]  exp_size = 2'd0;
    bit          mon_en = 0, lit_en = 0, frame_on = 0;
    bit          prev_ok = 0, prev_busy = 0;
    logic [38:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, {img_rd, img_addr, prm_addr, in_en, din, ipf_type, ipf_band_pos,
                     ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done}, 64'd0);
    endtask

    // Expected pixel stream: image coordinates of every pixel in LCU raster order.
    task automatic build_model(input int sz);
        int s, n;
        pix_t e;
        s = (sz == 0) ? 16 : (sz == 1) ? 32 : 64;
        n = 128 / s;
        exp_q.delete();
        for (int ly = 0; ly < n; ly++)
            for (int lx = 0; lx < n; lx++)
                for (int row = 0; row < s; row++)
                    for (int col = 0; col < s; col++) begin
                        e.addr = (ly * s + row) * 128 + lx * s + col;
                        e.din  = img_rom[e.addr];
                        e.prm  = prm_rom[ly * n + lx];
                        e.lx   = 3'(lx);
                        e.ly   = 3'(ly);
                        exp_q.push_back(e);
                    end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (prev_ok && prev_busy)
                check("freeze", {in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y}, prev_out);
            if (in_en && !busy) begin
                if (exp_q.size() == 0) begin
                    check("extra_pixel", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("din", din, mon_e.din);
                    check("params", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, mon_e.prm);
                    check("lcu_xy", {lcu_x, lcu_y}, {mon_e.lx, mon_e.ly});
                    if (lit_en && pix_cnt == 256) begin
                        check("px256_lcu_x", lcu_x, 64'd1);
                        check("px256_params", {ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, prm_rom[1]);
                    end
                    pix_cnt++;
                    last_en_cyc = cyc;
                    last_din = din;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (img_rd) prm_seen[prm_addr] = 1'b1;
            if (frame_on) check("lcu_size", lcu_size, exp_size);
            if (cyc == t0 + 1) check("first_read", {img_rd, img_addr}, {1'b1, 14'd0});
            if (cyc == t0 + 3) check("first_pixel", {in_en, din}, {1'b1, img_rom[0]});
            if (lit_en && cyc == t0 + 257) check("read256_addr", {img_addr, prm_addr}, {14'd16, 6'd1});
            if (lit_en && cyc == t0 + 263) check("boundary_hold", {in_en, lcu_x}, {1'b1, 3'd0});
            if (lit_en && cyc == t0 + 264) check("boundary_switch", {in_en, lcu_x}, {1'b1, 3'd1});
        end
        prev_ok   = mon_en && !reset;
        prev_busy = busy;
        prev_out  = {in_en, din, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, lcu_x, lcu_y};
    end

    task automatic run_frame(input int sz, input int stall_at, input int stall_len,
                             input bit rnd, input bit poke, input bit lit);
        int k;
        @(posedge clk); #1;
        build_model(sz);
        exp_size = (sz == 3) ? 2'd2 : 2'(sz);
        lit_en = lit;
        pix_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        lcu_size_cfg = 2'(sz);
        start = 1'b1;
        t0 = cyc;
        mon_en = 1;
        @(posedge clk); #1;
        start = 1'b0;
        frame_on = 1;
        k = 1;
        while (exp_q.size() != 0 && k < 40000) begin
            busy = (k >= stall_at && k < stall_at + stall_len) || (rnd && k > 10 && $urandom_range(0, 7) == 0);
            if (poke && k == 100) begin
                start = 1'b1;
                finish = 1'b1;
                lcu_size_cfg = 2'd0;
            end else begin
                start = 1'b0;
                finish = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        busy = 1'b0;
        start = 1'b0;
        finish = 1'b0;
        check("frame_all_pixels", exp_q.size(), 64'd0);
        repeat (2) @(posedge clk);
        #1 finish = 1'b1;
        fin_cyc = cyc;
        @(negedge clk);
        check("drain_hold", {in_en, din}, {1'b0, last_din});
        @(posedge clk); #1 finish = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("done_pulses", done_cnt, 64'd1);
        check("done_timing", done_cyc, fin_cyc + 1);
        frame_on = 0;
        lit_en = 0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required frame completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) img_rom[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) prm_rom[i] = 24'($urandom);
        reset = 1'b1; start = 1'b0; finish = 1'b0; busy = 1'b0; lcu_size_cfg = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset_state");
        @(posedge clk); #1 reset = 1'b0;

        build_model(0);
        check("model_px256_addr", exp_q[256].addr, 64'd16);
        check("model_last_addr", exp_q[16383].addr, 64'd16383);
        build_model(2);
        check("model_s64_row1_addr", exp_q[64].addr, 64'd128);
        exp_q.delete();

        // 16x16 with a 5-cycle stall landing on the LCU boundary pixel #255
        run_frame(0, 258, 5, 1'b0, 1'b0, 1'b1);
        // 32x32 with random stalls, a 5-cycle stall mid-LCU, and stray start/finish
        run_frame(1, 500, 5, 1'b1, 1'b1, 1'b0);

        // abort a 64x64 (code 3) frame with reset
        @(posedge clk); #1;
        build_model(3);
        exp_size = 2'd2;
        lcu_size_cfg = 2'd3;
        start = 1'b1;
        t0 = cyc;
        mon_en = 1;
        @(posedge clk); #1;
        start = 1'b0;
        frame_on = 1;
        repeat (200) @(posedge clk);
        #1;
        frame_on = 0;
        mon_en = 0;
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_zero("abort_reset");

        // clean 64x64 restart: full pixel count, LCU count and last-pixel timing
        prm_seen = '0;
        run_frame(2, 0, 0, 1'b0, 1'b0, 1'b0);
        check("s64_pixels", pix_cnt, 64'd16384);
        check("s64_last_in_en", last_en_cyc, t0 + 16386);
        check("s64_lcus", prm_seen, 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
